// File: rtl/mem_read_arbiter.sv
// Two-requester burst-read arbiter: latches i-cache/d-cache refill requests, issues one downstream burst at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the d-cache (requester 1) has fixed priority.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_read_arbiter #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int MAX_WORDS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] req_base      [2],
  input  logic [ADDR_WIDTH-1:0] req_length    [2],
  input  logic [1:0]            req_go,
  output logic [1:0]            req_done,
  output logic [1:0]            req_available,
  output logic [DATA_WIDTH-1:0] req_data,
  input  logic [1:0]            req_re,
  output logic [ADDR_WIDTH-1:0] mem_base,
  output logic [ADDR_WIDTH-1:0] mem_length,
  output logic                  mem_go,
  input  logic                  mem_done,
  input  logic                  mem_available,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_re
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

  state_t                  state_reg;
  logic                    owner_reg;
  logic [CW-1:0]           count_reg;
  logic [1:0]              pend_reg;
  logic [ADDR_WIDTH-1:0]   base_reg [2];
  logic [ADDR_WIDTH-1:0]   len_reg  [2];
  logic                    mem_go_reg;
  logic [ADDR_WIDTH-1:0]   mem_base_reg;
  logic [ADDR_WIDTH-1:0]   mem_length_reg;

  logic                    in_burst;
  logic                    word_acc;
  logic [ADDR_WIDTH-1:0]   owner_words;
  logic                    last_word;
  logic                    zero_issue;
  logic [1:0]              pend_clr;
  logic                    grant_next;

  assign in_burst    = (state_reg == BURST);
  assign word_acc    = in_burst & mem_available & req_re[owner_reg];
  assign owner_words = len_reg[owner_reg] >> 2;
  assign last_word   = word_acc && ((ADDR_WIDTH'(count_reg) + ADDR_WIDTH'(1)) == owner_words);
  assign zero_issue  = (state_reg == ISSUE) && (len_reg[owner_reg] == '0);
  assign pend_clr    = (last_word || zero_issue) ? (owner_reg ? 2'b10 : 2'b01) : 2'b00;

`ifdef MEM_ARB_RR_EN
  logic last_grant_reg;
  // With both pending, alternate away from whoever was issued last.
  assign grant_next = (&pend_reg) ? ~last_grant_reg : pend_reg[1];
`else
  assign grant_next = pend_reg[1];
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_reg[gi] <= 1'b0;
          base_reg[gi] <= '0;
          len_reg[gi]  <= '0;
        end else if (pend_clr[gi]) begin
          pend_reg[gi] <= 1'b0;
        end else if (req_go[gi] && !pend_reg[gi]) begin
          pend_reg[gi] <= 1'b1;
          base_reg[gi] <= req_base[gi];
          len_reg[gi]  <= req_length[gi];
        end
      end

      always @(posedge clk) begin
        if (rst_n && req_go[gi]) begin
          assert (!pend_reg[gi])
            else $error("%m: req_go[%0d] while a request is still pending", gi);
          assert (pend_reg[gi] || ((req_length[gi] != '0) && (req_length[gi][1:0] == 2'b00) &&
                                   (req_length[gi] <= ADDR_WIDTH'(MAX_WORDS * 4))))
            else $error("%m: illegal burst length %0d on requester %0d", req_length[gi], gi);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      count_reg      <= '0;
      mem_go_reg     <= 1'b0;
      mem_base_reg   <= '0;
      mem_length_reg <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          mem_go_reg <= 1'b0;
          if ((|pend_reg) && mem_done) begin
            owner_reg      <= grant_next;
            mem_base_reg   <= base_reg[grant_next];
            mem_length_reg <= len_reg[grant_next];
            // A zero-length request retires in ISSUE without reaching the memory.
            mem_go_reg     <= (len_reg[grant_next] != '0);
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          mem_go_reg <= 1'b0;
          count_reg  <= '0;
`ifdef MEM_ARB_RR_EN
          last_grant_reg <= owner_reg;
`endif
          state_reg  <= zero_issue ? IDLE : BURST;
        end
        BURST: begin
          if (word_acc) count_reg <= count_reg + CW'(1);
          if (last_word) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_done      = ~pend_reg;
  assign req_available = (in_burst && mem_available) ? (owner_reg ? 2'b10 : 2'b01) : 2'b00;
  assign req_data      = mem_data;
  assign mem_re        = in_burst & req_re[owner_reg];
  assign mem_go        = mem_go_reg;
  assign mem_base      = mem_base_reg;
  assign mem_length    = mem_length_reg;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed scenarios plus randomized bursts against a request-level model.
`timescale 1ns/1ps
module tb_mem_read_arbiter;
  localparam int AW = 26;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] req_base   [2];
  logic [AW-1:0] req_length [2];
  logic [1:0]    req_go;
  logic [1:0]    req_done;
  logic [1:0]    req_available;
  logic [DW-1:0] req_data;
  logic [1:0]    req_re;
  logic [AW-1:0] mem_base;
  logic [AW-1:0] mem_length;
  logic          mem_go;
  logic          mem_done;
  logic          mem_available;
  logic [DW-1:0] mem_data;
  logic          mem_re;

  always #5 clk = ~clk;

  mem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORDS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_base(req_base), .req_length(req_length), .req_go(req_go),
    .req_done(req_done), .req_available(req_available), .req_data(req_data), .req_re(req_re),
    .mem_base(mem_base), .mem_length(mem_length), .mem_go(mem_go), .mem_done(mem_done),
    .mem_available(mem_available), .mem_data(mem_data), .mem_re(mem_re)
  );

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return (DW'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  int npass = 0;
  int nchk  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Memory read master model: one burst at a time, data is a function of address.
  logic          mem_busy = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  int            mem_left = 0;
  logic          avail_bit = 1'b1;
  logic          hold = 1'b0, flush = 1'b0, avail_rand = 1'b0, rand_re = 1'b0;
  int            proto_err = 0;

  assign mem_done      = !mem_busy && !hold;
  assign mem_available = mem_busy && avail_bit;
  assign mem_data      = word_at(mem_addr);

  always @(posedge clk) begin
    logic s_go, s_acc, s_flush;
    logic [AW-1:0] s_base, s_len;
    s_go = mem_go; s_acc = mem_available && mem_re; s_flush = flush;
    s_base = mem_base; s_len = mem_length;
    #1;
    if (s_flush) mem_busy = 1'b0;
    else if (s_go) begin
      if (mem_busy) proto_err++;
      mem_busy = 1'b1; mem_addr = s_base; mem_left = int'(s_len >> 2);
    end else if (s_acc) begin
      mem_addr = mem_addr + AW'(4);
      mem_left--;
      if (mem_left == 0) mem_busy = 1'b0;
    end
    avail_bit = avail_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: logs issued bursts, words seen by each requester and event cycles.
  typedef struct { int cyc; logic [AW-1:0] base; logic [AW-1:0] len; int gap; } burst_t;
  burst_t        go_log[$];
  logic [DW-1:0] rx0[$], rx1[$];
  int cyc = 0, last_acc_cyc = -100, md_rise_cyc = 0, last_go_cyc = 0;
  int go_cyc[2], last_word_cyc[2], done_rise_cyc[2];
  logic [1:0] prev_done = 2'b11;
  logic prev_md = 1'b1, prev_go = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (req_go[k]) go_cyc[k] = cyc;
      if (req_done[k] && !prev_done[k]) done_rise_cyc[k] = cyc;
    end
    if (req_available[0] && req_re[0]) begin rx0.push_back(req_data); last_word_cyc[0] = cyc; end
    if (req_available[1] && req_re[1]) begin rx1.push_back(req_data); last_word_cyc[1] = cyc; end
    if (&req_available) proto_err++;
    if ((|req_available) && !mem_available) proto_err++;
    if (mem_go && prev_go) proto_err++;
    if (mem_go) begin
      go_log.push_back('{cyc, mem_base, mem_length, cyc - last_acc_cyc});
      last_go_cyc = cyc;
    end
    if (mem_available && mem_re) last_acc_cyc = cyc;
    if (mem_done && !prev_md) md_rise_cyc = cyc;
    prev_done = req_done; prev_md = mem_done; prev_go = mem_go;
    cyc++;
  end

  // Reference model: per-request expectations in grant order.
  typedef struct { logic [AW-1:0] base; logic [AW-1:0] len; bit chk_gap; } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] exp0[$], exp1[$];
  bit            model_last = 1'b1;

  task automatic model_burst(input int k, input logic [AW-1:0] b, input logic [AW-1:0] l, input bit gap);
    exp_q.push_back('{b, l, gap});
    for (int i = 0; i < int'(l) / 4; i++) begin
      if (k == 0) exp0.push_back(word_at(b + AW'(4 * i)));
      else        exp1.push_back(word_at(b + AW'(4 * i)));
    end
    model_last = (k == 1);
  endtask

  task automatic model_pair(input logic [AW-1:0] b0, input logic [AW-1:0] l0,
                            input logic [AW-1:0] b1, input logic [AW-1:0] l1);
    bit first;
`ifdef MEM_ARB_RR_EN
    first = !model_last;
`else
    first = 1'b1;
`endif
    if (!first) begin model_burst(0, b0, l0, 1'b0); model_burst(1, b1, l1, 1'b1); end
    else        begin model_burst(1, b1, l1, 1'b0); model_burst(0, b0, l0, 1'b1); end
  endtask

  task automatic verify(input string tag);
    exp_t e; burst_t g;
    chk({tag, ":bursts"}, 64'(go_log.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && go_log.size() > 0) begin
      e = exp_q.pop_front(); g = go_log.pop_front();
      $display("[tb] %s burst base=%h len=%0d gap=%0d", tag, g.base, g.len, g.gap);
      chk({tag, ":base"}, 64'(g.base), 64'(e.base));
      chk({tag, ":len"}, 64'(g.len), 64'(e.len));
      if (e.chk_gap) chk({tag, ":gap"}, 64'(g.gap), 64'd2);
    end
    exp_q.delete(); go_log.delete();
    chk({tag, ":words0"}, 64'(rx0.size()), 64'(exp0.size()));
    while (rx0.size() > 0 && exp0.size() > 0) chk({tag, ":data0"}, 64'(rx0.pop_front()), 64'(exp0.pop_front()));
    chk({tag, ":words1"}, 64'(rx1.size()), 64'(exp1.size()));
    while (rx1.size() > 0 && exp1.size() > 0) chk({tag, ":data1"}, 64'(rx1.pop_front()), 64'(exp1.pop_front()));
    rx0.delete(); rx1.delete(); exp0.delete(); exp1.delete();
    $display("[tb] %s complete, model last grant %0d", tag, model_last);
  endtask

  task automatic go(input int k, input logic [AW-1:0] b, input logic [AW-1:0] l);
    @(posedge clk); #1;
    req_base[k] = b; req_length[k] = l; req_go[k] = 1'b1;
    @(posedge clk); #1;
    req_go[k] = 1'b0;
  endtask

  task automatic go2(input logic [AW-1:0] b0, input logic [AW-1:0] l0,
                     input logic [AW-1:0] b1, input logic [AW-1:0] l1);
    @(posedge clk); #1;
    req_base[0] = b0; req_length[0] = l0; req_base[1] = b1; req_length[1] = l1; req_go = 2'b11;
    @(posedge clk); #1;
    req_go = 2'b00;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (rand_re) req_re = 2'($urandom);
      if (req_done == 2'b11 && mem_done) begin ok = 1'b1; break; end
    end
    req_re = 2'b11;
    chk({tag, ":finished_in_time"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_words(input string tag, input int k, input int n, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if ((k == 0 ? rx0.size() : rx1.size()) >= n) begin ok = 1'b1; break; end
    end
    chk({tag, ":words_in_time"}, 64'(ok), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_last = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", npass, nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_n = 1'b0; req_go = 2'b00; req_re = 2'b11;
    req_base[0] = '0; req_base[1] = '0; req_length[0] = '0; req_length[1] = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst:req_done", 64'(req_done), 64'd3);
    chk("rst:req_available", 64'(req_available), 64'd0);
    chk("rst:mem_go", 64'(mem_go), 64'd0);
    chk("rst:mem_re", 64'(mem_re), 64'd0);
    chk("rst:mem_base", 64'(mem_base), 64'd0);
    chk("rst:mem_length", 64'(mem_length), 64'd0);
    rst_n = 1'b1;

    // Single i-cache burst
    go(0, 26'h100, 26'd16);
    model_burst(0, 26'h100, 26'd16, 1'b0);
    wait_idle("t1", 200);
    chk("t1:go_latency", 64'(last_go_cyc - go_cyc[0]), 64'd2);
    chk("t1:done_after_last", 64'(done_rise_cyc[0] - last_word_cyc[0]), 64'd1);
    verify("t1");

    // Simultaneous requests from a fresh reset
    do_reset();
    go2(26'h200, 26'd16, 26'h400, 26'd32);
    model_pair(26'h200, 26'd16, 26'h400, 26'd32);
    wait_idle("t2", 400);
    verify("t2");

    // d-cache request arrives mid i-cache burst
    go(0, 26'h800, 26'd64);
    wait_words("t3", 0, 5, 200);
    go(1, 26'hC00, 26'd8);
    model_burst(0, 26'h800, 26'd64, 1'b0);
    model_burst(1, 26'hC00, 26'd8, 1'b1);
    wait_idle("t3", 400);
    verify("t3");

    // Toggling mem_available and a 3-cycle owner stall
    avail_rand = 1'b1;
    go(1, 26'h600, 26'd32);
    model_burst(1, 26'h600, 26'd32, 1'b0);
    wait_words("t4", 1, 2, 200);
    req_re[1] = 1'b0;
    n0 = rx1.size();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4:mem_re_stalled", 64'(mem_re), 64'd0);
    end
    @(posedge clk); #1;
    chk("t4:no_words_in_stall", 64'(rx1.size()), 64'(n0));
    req_re = 2'b11;
    wait_idle("t4", 400);
    avail_rand = 1'b0;
    verify("t4");

    // Downstream busy holds off issue
    @(posedge clk); #1 hold = 1'b1;
    go(0, 26'h500, 26'd16);
    model_burst(0, 26'h500, 26'd16, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("t5:no_go_while_busy", 64'(go_log.size()), 64'd0);
    chk("t5:still_pending", 64'(req_done[0]), 64'd0);
    hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5:issue_after_done", 64'(last_go_cyc - md_rise_cyc), 64'd1);
    wait_idle("t5", 200);
    verify("t5");

    // Reset in the middle of a burst
    go(0, 26'h300, 26'd16);
    wait_words("t6", 0, 2, 200);
    rst_n = 1'b0;
    #1;
    chk("t6:req_done", 64'(req_done), 64'd3);
    chk("t6:req_available", 64'(req_available), 64'd0);
    chk("t6:mem_go", 64'(mem_go), 64'd0);
    chk("t6:mem_re", 64'(mem_re), 64'd0);
    chk("t6:mem_base", 64'(mem_base), 64'd0);
    chk("t6:mem_length", 64'(mem_length), 64'd0);
    @(posedge clk); #1;
    chk("t6:late_word_offered", 64'(mem_available), 64'd1);
    chk("t6:late_word_refused", 64'(mem_re), 64'd0);
    flush = 1'b1;
    repeat (2) @(posedge clk);
    #1 flush = 1'b0;
    rst_n = 1'b1;
    model_last = 1'b1;
    chk("t6:words_before_reset", 64'(rx0.size()), 64'd2);
    chk("t6:bursts_before_reset", 64'(go_log.size()), 64'd1);
    rx0.delete(); go_log.delete();
    go(1, 26'h700, 26'd16);
    model_burst(1, 26'h700, 26'd16, 1'b0);
    wait_idle("t6b", 200);
    verify("t6b");

    // Randomized requests, stalls and data gaps
    avail_rand = 1'b1; rand_re = 1'b1;
    for (int it = 0; it < 16; it++) begin
      int mode;
      logic [AW-1:0] b0, b1, l0, l1;
      mode = $urandom_range(0, 2);
      b0 = AW'($urandom) & ~AW'(3);
      b1 = AW'($urandom) & ~AW'(3);
      l0 = AW'(4 * $urandom_range(1, 16));
      l1 = AW'(4 * $urandom_range(1, 16));
      if (mode == 0)      begin go(0, b0, l0); model_burst(0, b0, l0, 1'b0); end
      else if (mode == 1) begin go(1, b1, l1); model_burst(1, b1, l1, 1'b0); end
      else                begin go2(b0, l0, b1, l1); model_pair(b0, l0, b1, l1); end
      wait_idle("rnd", 3000);
      verify($sformatf("rnd%0d", it));
    end
    avail_rand = 1'b0; rand_re = 1'b0;

    chk("protocol_errors", 64'(proto_err), 64'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
